// File: rtl/fft256_buf_ctrl.sv
// rtl/fft256_buf_ctrl.sv - sequencing controller for the FFT256 256-word single-port sample RAM
//
// Purpose:
//    Writes 256 upstream samples into the RAM in natural order. It then reads them
//    back, half-duplex on the same port, in bit-reversed order (FFT256_BITREV_EN
//    defined) or in natural order (FFT256_BITREV_EN undefined). A DO_VALID/DO_FIRST
//    strobe is produced that lines up with the RAM's registered read data. The
//    data bus does not pass through this block.
//
// Configuration macro: FFT256_BITREV_EN (read order = bit-reverse of the 8-bit index)
//
// Ports:
//    CLK       in   1  clock, rising edge
//    RST_N     in   1  synchronous active-low reset (independent of ED)
//    ED        in   1  enable; all state advances only on ED=1 edges
//    START     in   1  frame request, sampled on ED edges
//    RAM_ED    out  1  RAM enable, combinational copy of ED
//    RAM_WE    out  1  RAM write enable (registered)
//    RAM_ADDR  out  8  RAM address (registered)
//    DI_REQ    out  1  upstream sample consumed this cycle (= RAM_WE)
//    DO_VALID  out  1  RAM data output holds a frame sample
//    DO_FIRST  out  1  RAM data output holds sample index 0 of the frame
//    BUSY      out  1  controller is writing or reading a frame
//    ERR       out  1  one-ED-cycle pulse: START seen while BUSY

module fft256_buf_ctrl (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       ED,
   input  logic       START,
   output logic       RAM_ED,
   output logic       RAM_WE,
   output logic [7:0] RAM_ADDR,
   output logic       DI_REQ,
   output logic       DO_VALID,
   output logic       DO_FIRST,
   output logic       BUSY,
   output logic       ERR
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [7:0] r_addr;
   logic [7:0] w_addr_nxt;
   logic       r_we;
   logic       w_we_nxt;
   logic       r_err;
   logic       w_err_nxt;
   logic [1:0] r_vpipe;
   logic [1:0] r_fpipe;
   logic [7:0] w_cnt_inc;
   logic       w_rd;
   logic       w_rd_first;

   // Readback order of frame index k.
   function automatic logic [7:0] f_order(input logic [7:0] k);
`ifdef FFT256_BITREV_EN
      f_order = {k[0], k[1], k[2], k[3], k[4], k[5], k[6], k[7]};
`else
      f_order = k;
`endif
   endfunction

   assign w_cnt_inc  = r_cnt + 8'd1;
   // A read address is on RAM_ADDR for the whole READ state; the RAM then needs
   // two enabled edges (address register, data register) before DO shows it.
   assign w_rd       = (r_state == S_READ);
   assign w_rd_first = w_rd && (r_cnt == 8'd0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_we_nxt    = r_we;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_we_nxt = 1'b0;
            if (START) begin
               w_state_nxt = S_WRITE;
               w_we_nxt    = 1'b1;
               w_addr_nxt  = 8'd0;
               w_cnt_nxt   = 8'd0;
            end
         end
         S_WRITE: begin
            w_err_nxt = START;
            if (r_cnt == 8'd255) begin
               // This edge writes address 255; switch the port to reading.
               w_state_nxt = S_READ;
               w_we_nxt    = 1'b0;
               w_cnt_nxt   = 8'd0;
               w_addr_nxt  = f_order(8'd0);
            end else begin
               w_cnt_nxt  = w_cnt_inc;
               w_addr_nxt = w_cnt_inc;
            end
         end
         S_READ: begin
            if (r_cnt == 8'd255) begin
               // Last read address has been taken by the RAM. A START here is
               // accepted directly so back-to-back frames keep a 512-edge period;
               // the next write begins at address 0, never clashing with 255.
               w_cnt_nxt  = 8'd0;
               w_addr_nxt = 8'd0;
               if (START) begin
                  w_state_nxt = S_WRITE;
                  w_we_nxt    = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_we_nxt    = 1'b0;
               end
            end else begin
               w_err_nxt  = START;
               w_cnt_nxt  = w_cnt_inc;
               w_addr_nxt = f_order(w_cnt_inc);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_we_nxt    = 1'b0;
            w_cnt_nxt   = 8'd0;
            w_addr_nxt  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_addr  <= 8'd0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_vpipe <= 2'b00;
         r_fpipe <= 2'b00;
      end else if (ED) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_addr  <= w_addr_nxt;
         r_we    <= w_we_nxt;
         r_err   <= w_err_nxt;
         r_vpipe <= {r_vpipe[0], w_rd};
         r_fpipe <= {r_fpipe[0], w_rd_first};
      end
   end

   assign RAM_ED   = ED;
   assign RAM_WE   = r_we;
   assign RAM_ADDR = r_addr;
   assign DI_REQ   = r_we;
   assign DO_VALID = r_vpipe[1];
   assign DO_FIRST = r_fpipe[1];
   assign BUSY     = (r_state != S_IDLE);
   assign ERR      = r_err;

endmodule

// File: tb/tb_fft256_buf_ctrl.sv
// tb/tb_fft256_buf_ctrl.sv - randomized self-checking bench for fft256_buf_ctrl

module tb_fft256_buf_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       ED;
   logic       START;
   logic       RAM_ED;
   logic       RAM_WE;
   logic [7:0] RAM_ADDR;
   logic       DI_REQ;
   logic       DO_VALID;
   logic       DO_FIRST;
   logic       BUSY;
   logic       ERR;

   int tests = 0;
   int fails = 0;

`ifdef FFT256_BITREV_EN
   localparam int LIT_ADDR_R1 = 128;
   localparam int LIT_ADDR_R3 = 192;
`else
   localparam int LIT_ADDR_R1 = 1;
   localparam int LIT_ADDR_R3 = 3;
`endif

   fft256_buf_ctrl dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .ED       (ED),
      .START    (START),
      .RAM_ED   (RAM_ED),
      .RAM_WE   (RAM_WE),
      .RAM_ADDR (RAM_ADDR),
      .DI_REQ   (DI_REQ),
      .DO_VALID (DO_VALID),
      .DO_FIRST (DO_FIRST),
      .BUSY     (BUSY),
      .ERR      (ERR)
   );

   always #5 CLK = ~CLK;

   function automatic int border(input int k);
      logic [7:0] kk;
      logic [7:0] r;
      kk = k[7:0];
`ifdef FFT256_BITREV_EN
      for (int b = 0; b < 8; b++) r[7-b] = kk[b];
`else
      r = kk;
`endif
      return int'(r);
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model state ----------------
   int          e_cnt = 0;          // count of ED=1 non-reset edges
   bit          have_cur = 0, have_prev = 0;
   int          s_cur = 0, s_prev = 0;
   int          slot_cur = 0, slot_prev = 0;
   int          fid = 0;
   bit          m_err = 0;
   logic [15:0] fdata [2][256];
   // environment RAM: address register then data register
   logic [15:0] mem [256];
   logic [7:0]  areg = 8'd0;
   logic [15:0] ram_do = 16'd0;
   logic        p_we = 1'b0;
   logic [7:0]  p_addr = 8'd0;
   logic [15:0] p_di = 16'd0;

   always @(posedge CLK) begin
      bit s_rstn, s_ed, s_start;
      int j, jp;
      int e_busy, e_we, e_addr, e_v, e_f, e_do;
      logic [15:0] m_di;
      s_rstn  = RST_N;
      s_ed    = ED;
      s_start = START;
      #1;
      if (s_ed) begin
         ram_do = mem[areg];
         areg   = p_addr;
         if (p_we) mem[p_addr] = p_di;
      end
      if (!s_rstn) begin
         have_cur  = 0;
         have_prev = 0;
         m_err     = 0;
      end else if (s_ed) begin
         e_cnt++;
         m_err = 0;
         if (!have_cur || (e_cnt - s_cur) >= 512) begin
            if (s_start) begin
               have_prev = have_cur;
               s_prev    = s_cur;
               slot_prev = slot_cur;
               have_cur  = 1;
               s_cur     = e_cnt;
               fid++;
               slot_cur  = fid % 2;
               for (int n = 0; n < 256; n++) fdata[slot_cur][n] = 16'($urandom);
            end
         end else begin
            m_err = s_start;
         end
      end
      e_busy = 0; e_we = 0; e_addr = 0; e_v = 0; e_f = 0; e_do = 0;
      m_di = 16'd0;
      j = e_cnt - s_cur;
      if (have_prev) begin
         jp = e_cnt - s_prev;
         if (jp >= 258 && jp <= 513) begin
            e_v  = 1;
            e_f  = (jp == 258) ? 1 : 0;
            e_do = int'(fdata[slot_prev][border(jp - 258)]);
         end
      end
      if (have_cur) begin
         if (j <= 511) e_busy = 1;
         if (j <= 255) begin
            e_we   = 1;
            e_addr = j;
            m_di   = fdata[slot_cur][j];
         end else if (j <= 511) begin
            e_addr = border(j - 256);
         end
         if (j >= 258 && j <= 513) begin
            e_v  = 1;
            e_f  = (j == 258) ? 1 : 0;
            e_do = int'(fdata[slot_cur][border(j - 258)]);
         end
      end
      chk("RAM_ED", int'(RAM_ED), int'(ED));
      chk("BUSY", int'(BUSY), e_busy);
      chk("RAM_WE", int'(RAM_WE), e_we);
      chk("DI_REQ", int'(DI_REQ), e_we);
      chk("RAM_ADDR", int'(RAM_ADDR), e_addr);
      chk("DO_VALID", int'(DO_VALID), e_v);
      chk("DO_FIRST", int'(DO_FIRST), e_f);
      chk("ERR", int'(ERR), int'(m_err));
      if (e_v != 0 && DO_VALID) chk("DO_DATA", int'(ram_do), e_do);
      // hand-computed anchors of the frame timeline
      if (have_cur && s_ed && s_rstn) begin
         case (j)
            0:   begin chk("e0_addr", int'(RAM_ADDR), 0); chk("e0_we", int'(RAM_WE), 1); end
            1:   chk("e1_addr", int'(RAM_ADDR), 1);
            255: chk("e255_addr", int'(RAM_ADDR), 255);
            256: begin chk("e256_we", int'(RAM_WE), 0); chk("e256_addr", int'(RAM_ADDR), 0); end
            257: chk("e257_addr", int'(RAM_ADDR), LIT_ADDR_R1);
            259: chk("e259_addr", int'(RAM_ADDR), LIT_ADDR_R3);
            258: begin chk("e258_valid", int'(DO_VALID), 1); chk("e258_first", int'(DO_FIRST), 1); end
            257 + 0: ;
            511: chk("e511_addr", int'(RAM_ADDR), 255);
            512: begin chk("e512_busy", int'(BUSY), 0); chk("e512_addr", int'(RAM_ADDR), 0); end
            default: ;
         endcase
         if (j == 257) chk("e257_valid", int'(DO_VALID), 0);
      end
      if (!s_rstn) begin
         chk("rst_busy", int'(BUSY), 0);
         chk("rst_valid", int'(DO_VALID), 0);
         chk("rst_addr", int'(RAM_ADDR), 0);
      end
      p_we   = RAM_WE;
      p_addr = RAM_ADDR;
      p_di   = m_di;
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit ed, input bit st, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RST_N = 1'b1;
         ED    = ed;
         START = st;
      end
   endtask

   task automatic rst1(input bit ed);
      @(negedge CLK);
      RST_N = 1'b0;
      ED    = ed;
      START = 1'b0;
   endtask

   task automatic rand_ed(input int n, input int start_mod);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RST_N = 1'b1;
         ED    = 1'($urandom % 2);
         START = (start_mod > 0) ? (($urandom % start_mod) == 0) : 1'b0;
      end
   endtask

   initial begin
      RST_N = 1'b0;
      ED    = 1'b0;
      START = 1'b0;
      rst1(1'b1);
      rst1(1'b0);
      rst1(1'b1);
      // single frame, ED always high
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 600);
      // ED toggling during a frame
      cyc(1'b1, 1'b1, 1);
      rand_ed(1300, 0);
      cyc(1'b1, 1'b0, 10);
      // START at e100 (error) and at e512 (back-to-back)
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 99);
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 411);
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 600);
      // reset mid-read at e300 with ED low, then a fresh frame
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 299);
      rst1(1'b0);
      cyc(1'b1, 1'b0, 5);
      cyc(1'b1, 1'b1, 1);
      cyc(1'b1, 1'b0, 600);
      // START held high
      cyc(1'b1, 1'b1, 1100);
      cyc(1'b1, 1'b0, 600);
      // random ED and random START
      rand_ed(1500, 40);
      cyc(1'b1, 1'b0, 600);
      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
